// File: rtl/ec_bucket_scheduler.sv
// Issue scheduler for a pipelined point adder in MSM bucket accumulation.
// Ports: clk, rst (async high); in_valid/in_ready/in_bucket/in_tag request
// stream; issue_* adder issue; done_* writeback strobe after LAT cycles;
// inflight, fifo_count, idle status.
module ec_bucket_scheduler #(
    parameter int WB  = 10,
    parameter int M   = 32,
    parameter int LAT = 82,
    parameter int DQ  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WB-1:0]            in_bucket,
    input  logic [M-1:0]             in_tag,
    output logic                     issue_valid,
    output logic [WB-1:0]            issue_bucket,
    output logic [M-1:0]             issue_tag,
    output logic                     done_valid,
    output logic [WB-1:0]            done_bucket,
    output logic [M-1:0]             done_tag,
    output logic [$clog2(LAT+1):0]   inflight,
    output logic [$clog2(DQ):0]      fifo_count,
    output logic                     idle
);

    localparam int PW = $clog2(DQ);
    localparam int CW = $clog2(DQ) + 1;
    localparam int IW = $clog2(LAT + 1) + 1;
    localparam logic [CW-1:0] DEPTH = CW'(DQ);

    logic [(1<<WB)-1:0] busy;

    logic [WB-1:0] fq_bucket [DQ];
    logic [M-1:0]  fq_tag    [DQ];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    logic [LAT-1:0] dl_valid;
    logic [WB-1:0]  dl_bucket [LAT];
    logic [M-1:0]   dl_tag    [LAT];

    logic          accept;
    logic          head_ok;
    logic          in_free;
    logic          push;
    logic          pop;
    logic          sel_valid;
    logic [WB-1:0] sel_bucket;
    logic [M-1:0]  sel_tag;

    // Only the registered count gates acceptance, so in_ready never
    // combinationally depends on in_valid or a same-cycle pop.
    assign in_ready = fifo_count < DEPTH;
    assign accept   = in_valid && in_ready;

    // The FIFO head outranks the input; a new request arriving while the
    // head drains goes to the tail even if its bucket is free.
    always_comb begin
        head_ok    = (fifo_count != '0) && !busy[fq_bucket[rd_ptr]];
        in_free    = !busy[in_bucket];
        pop        = head_ok;
        push       = accept && (head_ok || !in_free);
        sel_valid  = head_ok || (accept && in_free);
        sel_bucket = in_bucket;
        sel_tag    = in_tag;
        if (head_ok) begin
            sel_bucket = fq_bucket[rd_ptr];
            sel_tag    = fq_tag[rd_ptr];
        end
    end

    // Clear on writeback and set on issue always hit different buckets,
    // so the two updates never collide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            if (done_valid) busy[done_bucket] <= 1'b0;
            if (sel_valid)  busy[sel_bucket]  <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fq_bucket[wr_ptr] <= in_bucket;
            fq_tag[wr_ptr]    <= in_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_valid  <= 1'b0;
            issue_bucket <= '0;
            issue_tag    <= '0;
        end else begin
            issue_valid  <= sel_valid;
            issue_bucket <= sel_bucket;
            issue_tag    <= sel_tag;
        end
    end

    // Mirrors the adder pipeline: stage LAT-1 lines up with the adder result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dl_valid <= '0;
            for (int i = 0; i < LAT; i++) begin
                dl_bucket[i] <= '0;
                dl_tag[i]    <= '0;
            end
        end else begin
            dl_valid     <= {dl_valid[LAT-2:0], issue_valid};
            dl_bucket[0] <= issue_bucket;
            dl_tag[0]    <= issue_tag;
            for (int i = 1; i < LAT; i++) begin
                dl_bucket[i] <= dl_bucket[i-1];
                dl_tag[i]    <= dl_tag[i-1];
            end
        end
    end

    assign done_valid  = dl_valid[LAT-1];
    assign done_bucket = dl_bucket[LAT-1];
    assign done_tag    = dl_tag[LAT-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            unique case ({issue_valid, done_valid})
                2'b10:   inflight <= inflight + IW'(1);
                2'b01:   inflight <= inflight - IW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    assign idle = (fifo_count == '0) && (inflight == '0) && !issue_valid;

    a_no_set_clear: assert property (@(posedge clk) disable iff (rst)
        !(sel_valid && done_valid && sel_bucket == done_bucket));
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && fifo_count == DEPTH));
    a_inflight_max: assert property (@(posedge clk) disable iff (rst)
        inflight <= IW'(LAT));

endmodule

// File: tb/tb_ec_bucket_scheduler.sv
// Self-checking bench for ec_bucket_scheduler.
// A queue model of FIFO, busy bits and adder pipeline checks every cycle.
module tb_ec_bucket_scheduler;

    localparam int WB  = 10;
    localparam int M   = 32;
    localparam int LAT = 82;
    localparam int DQ  = 16;

    typedef struct {
        int          c;
        logic [9:0]  b;
        logic [31:0] t;
    } ev_t;

    typedef struct {
        logic [9:0]  b;
        logic [31:0] t;
    } req_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [9:0]  in_bucket = '0;
    logic [31:0] in_tag = '0;
    logic        issue_valid;
    logic [9:0]  issue_bucket;
    logic [31:0] issue_tag;
    logic        done_valid;
    logic [9:0]  done_bucket;
    logic [31:0] done_tag;
    logic [7:0]  inflight;
    logic [4:0]  fifo_count;
    logic        idle;

    ec_bucket_scheduler #(.WB(WB), .M(M), .LAT(LAT), .DQ(DQ)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_bucket(in_bucket), .in_tag(in_tag),
        .issue_valid(issue_valid), .issue_bucket(issue_bucket),
        .issue_tag(issue_tag),
        .done_valid(done_valid), .done_bucket(done_bucket),
        .done_tag(done_tag),
        .inflight(inflight), .fifo_count(fifo_count), .idle(idle)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    req_t mq[$];
    ev_t  pend[$];
    bit   mbusy[1024];
    int   minfl;
    bit   miv;
    logic [9:0]  mib;
    logic [31:0] mit;

    ev_t iss_log[$];
    ev_t done_log[$];

    task automatic model_reset();
        mq.delete();
        pend.delete();
        foreach (mbusy[i]) mbusy[i] = 1'b0;
        minfl = 0;
        miv = 1'b0;
        mib = '0;
        mit = '0;
    endtask

    // Called at a negedge: checks the current cycle against the model,
    // then drives the next inputs and advances the model one cycle.
    task automatic tick(input bit v, input logic [9:0] b,
                        input logic [31:0] t, output bit acc);
        bit   dn, hok, sv, clash;
        logic [9:0] db;
        req_t s;
        if (issue_valid) iss_log.push_back('{cyc, issue_bucket, issue_tag});
        if (done_valid)  done_log.push_back('{cyc, done_bucket, done_tag});
        total++;
        if (issue_valid !== miv) begin
            bad++;
            $display("FAIL issue_valid cyc=%0d got=%b want=%b",
                     cyc, issue_valid, miv);
        end
        if (miv) begin
            total++;
            if (issue_bucket !== mib || issue_tag !== mit) begin
                bad++;
                $display("FAIL issue_data cyc=%0d got=%0d/%h want=%0d/%h",
                         cyc, issue_bucket, issue_tag, mib, mit);
            end
        end
        if (issue_valid) begin
            clash = 1'b0;
            foreach (pend[i]) if (pend[i].b == issue_bucket) clash = 1'b1;
            total++;
            if (clash) begin
                bad++;
                $display("FAIL hazard cyc=%0d bucket=%0d got=in_flight want=free",
                         cyc, issue_bucket);
            end
        end
        dn = pend.size() > 0 && pend[0].c == cyc;
        db = '0;
        total++;
        if (done_valid !== dn) begin
            bad++;
            $display("FAIL done_valid cyc=%0d got=%b want=%b",
                     cyc, done_valid, dn);
        end
        if (dn) begin
            db = pend[0].b;
            total++;
            if (done_bucket !== pend[0].b || done_tag !== pend[0].t) begin
                bad++;
                $display("FAIL done_data cyc=%0d got=%0d/%h want=%0d/%h",
                         cyc, done_bucket, done_tag, pend[0].b, pend[0].t);
            end
            void'(pend.pop_front());
        end
        total++;
        if (inflight !== 8'(minfl)) begin
            bad++;
            $display("FAIL inflight cyc=%0d got=%0d want=%0d",
                     cyc, inflight, minfl);
        end
        total++;
        if (fifo_count !== 5'(mq.size())) begin
            bad++;
            $display("FAIL fifo_count cyc=%0d got=%0d want=%0d",
                     cyc, fifo_count, mq.size());
        end
        total++;
        if (idle !== (mq.size() == 0 && minfl == 0 && !miv)) begin
            bad++;
            $display("FAIL idle cyc=%0d got=%b", cyc, idle);
        end
        total++;
        if (in_ready !== (mq.size() < DQ)) begin
            bad++;
            $display("FAIL in_ready cyc=%0d got=%b want=%b",
                     cyc, in_ready, mq.size() < DQ);
        end
        acc = v && mq.size() < DQ;
        hok = mq.size() > 0 && !mbusy[mq[0].b];
        sv = 1'b0;
        s = '{b, t};
        if (hok) begin
            s = mq.pop_front();
            sv = 1'b1;
            if (acc) mq.push_back('{b, t});
        end else if (acc && !mbusy[b]) begin
            sv = 1'b1;
        end else if (acc) begin
            mq.push_back('{b, t});
        end
        if (dn) mbusy[db] = 1'b0;
        if (sv) mbusy[s.b] = 1'b1;
        if (miv) pend.push_back('{cyc + LAT, mib, mit});
        minfl = minfl + int'(miv) - int'(dn);
        miv = sv;
        mib = s.b;
        mit = s.t;
        in_valid = v;
        in_bucket = b;
        in_tag = t;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input int maxc, output bit ok);
        bit a;
        int k = 0;
        while (!(idle === 1'b1 && pend.size() == 0 && mq.size() == 0 && !miv)
               && k < maxc) begin
            tick(1'b0, '0, '0, a);
            k++;
        end
        ok = (idle === 1'b1) && pend.size() == 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({issue_valid, done_valid, inflight, fifo_count, idle, in_ready}
            !== {1'b0, 1'b0, 8'd0, 5'd0, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL reset_ctrl got=%b%b/%0d/%0d/%b%b want=00/0/0/11",
                     issue_valid, done_valid, inflight, fifo_count, idle, in_ready);
        end
        total++;
        if ({issue_bucket, issue_tag, done_bucket, done_tag} !== '0) begin
            bad++;
            $display("FAIL reset_data got=%0d/%h/%0d/%h want=0",
                     issue_bucket, issue_tag, done_bucket, done_tag);
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_stream();
        bit a, ok;
        int t0, e, maxf;
        iss_log.delete();
        done_log.delete();
        t0 = cyc;
        maxf = 0;
        for (int i = 0; i < 101; i++) begin
            if (i < 100) tick(1'b1, 10'(i), 32'h100 + 32'(i), a);
            else         tick(1'b1, 10'h3ff, 32'hffff_ffff, a);
            if (int'(fifo_count) > maxf) maxf = int'(fifo_count);
        end
        drain(300, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL stream_idle got=%b want=1", idle);
        end
        total++;
        if (maxf != 0) begin
            bad++;
            $display("FAIL stream_fifo got=%0d want=0", maxf);
        end
        total++;
        if (iss_log.size() != 101 || done_log.size() != 101) begin
            bad++;
            $display("FAIL stream_count got=%0d/%0d want=101/101",
                     iss_log.size(), done_log.size());
        end else begin
            e = 0;
            for (int i = 0; i < 101; i++) begin
                if (iss_log[i].c != t0 + 1 + i) e++;
                if (done_log[i].c != t0 + 1 + i + LAT) e++;
                if (i < 100 && (iss_log[i].b != 10'(i) ||
                    done_log[i].t != 32'h100 + 32'(i))) e++;
            end
            if (iss_log[100].b != 10'h3ff || done_log[100].t != 32'hffff_ffff) e++;
            total++;
            if (e != 0) begin
                bad++;
                $display("FAIL stream_timing got=%0d errors want=0", e);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit a, ok;
        int t0;
        iss_log.delete();
        done_log.delete();
        t0 = cyc;
        tick(1'b1, 10'd5, 32'hA, a);
        tick(1'b1, 10'd5, 32'hB, a);
        total++;
        if (fifo_count !== 5'd1) begin
            bad++;
            $display("FAIL b2b_fifo got=%0d want=1", fifo_count);
        end
        tick(1'b0, '0, '0, a);
        drain(400, ok);
        total++;
        if (!ok || iss_log.size() != 2 || done_log.size() != 2) begin
            bad++;
            $display("FAIL b2b_count got=%0d/%0d want=2/2",
                     iss_log.size(), done_log.size());
        end else begin
            total++;
            if (iss_log[0].c != t0 + 1 || iss_log[1].c != t0 + 1 + LAT + 2 ||
                iss_log[0].t != 32'hA || iss_log[1].t != 32'hB) begin
                bad++;
                $display("FAIL b2b_issue got=%0d:%h,%0d:%h want=%0d:a,%0d:b",
                         iss_log[0].c - t0, iss_log[0].t, iss_log[1].c - t0,
                         iss_log[1].t, 1, LAT + 3);
            end
            total++;
            if (done_log[0].t != 32'hA || done_log[1].t != 32'hB ||
                done_log[0].c != t0 + 1 + LAT) begin
                bad++;
                $display("FAIL b2b_done got=%h,%h want=a,b",
                         done_log[0].t, done_log[1].t);
            end
        end
    endtask

    task automatic test_fifo_full();
        bit a, ok, low;
        int n, k, maxf, e;
        iss_log.delete();
        done_log.delete();
        n = 0;
        k = 0;
        maxf = 0;
        low = 1'b0;
        while (n < 17 && k < 3000) begin
            tick(1'b1, 10'd7, 32'h700 + 32'(n), a);
            if (a) n++;
            k++;
            if (in_ready === 1'b0) low = 1'b1;
            if (int'(fifo_count) > maxf) maxf = int'(fifo_count);
        end
        drain(2000, ok);
        total++;
        if (maxf != DQ || !low) begin
            bad++;
            $display("FAIL full_peak got=%0d/%b want=%0d/0", maxf, !low, DQ);
        end
        total++;
        if (!ok || iss_log.size() != 17) begin
            bad++;
            $display("FAIL full_count got=%0d want=17", iss_log.size());
        end else begin
            e = 0;
            for (int i = 0; i < 17; i++) begin
                if (iss_log[i].t != 32'h700 + 32'(i)) e++;
                if (i > 0 && iss_log[i].c - iss_log[i-1].c != LAT + 2) e++;
            end
            total++;
            if (e != 0) begin
                bad++;
                $display("FAIL full_spacing got=%0d errors want=0", e);
            end
        end
    endtask

    task automatic test_head_priority();
        bit a, ok;
        int t0;
        iss_log.delete();
        done_log.delete();
        t0 = cyc;
        tick(1'b1, 10'd3, 32'h31, a);
        tick(1'b1, 10'd3, 32'h32, a);
        while (cyc < t0 + LAT + 2) tick(1'b0, '0, '0, a);
        tick(1'b1, 10'd9, 32'h91, a);
        total++;
        if (fifo_count !== 5'd1) begin
            bad++;
            $display("FAIL head_fifo got=%0d want=1", fifo_count);
        end
        drain(400, ok);
        total++;
        if (!ok || iss_log.size() != 3) begin
            bad++;
            $display("FAIL head_count got=%0d want=3", iss_log.size());
        end else begin
            total++;
            if (iss_log[1].c != t0 + LAT + 3 || iss_log[1].t != 32'h32 ||
                iss_log[2].c != t0 + LAT + 4 || iss_log[2].b != 10'd9 ||
                iss_log[2].t != 32'h91) begin
                bad++;
                $display("FAIL head_order got=%0d:%h,%0d:%h want=%0d:32,%0d:91",
                         iss_log[1].c - t0, iss_log[1].t,
                         iss_log[2].c - t0, iss_log[2].t, LAT + 3, LAT + 4);
            end
        end
    endtask

    task automatic test_async_reset();
        bit a;
        int t0;
        for (int i = 0; i < 40; i++) tick(1'b1, 10'(100 + i), 32'h4000 + 32'(i), a);
        for (int i = 0; i < 4; i++) tick(1'b1, 10'(100 + i), 32'h5000 + 32'(i), a);
        total++;
        if (inflight !== 8'd40 || fifo_count !== 5'd4) begin
            bad++;
            $display("FAIL pre_reset got=%0d/%0d want=40/4", inflight, fifo_count);
        end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        total++;
        if ({issue_valid, done_valid, inflight, fifo_count, idle, in_ready}
            !== {1'b0, 1'b0, 8'd0, 5'd0, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL async_ctrl got=%b%b/%0d/%0d/%b%b want=00/0/0/11",
                     issue_valid, done_valid, inflight, fifo_count, idle, in_ready);
        end
        total++;
        if ({issue_bucket, issue_tag, done_bucket, done_tag} !== '0) begin
            bad++;
            $display("FAIL async_data got=%0d/%h want=0", issue_bucket, issue_tag);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        iss_log.delete();
        done_log.delete();
        t0 = cyc;
        tick(1'b1, 10'd100, 32'h6000, a);
        repeat (LAT + 20) tick(1'b0, '0, '0, a);
        total++;
        if (iss_log.size() != 1 || done_log.size() != 1) begin
            bad++;
            $display("FAIL post_reset_count got=%0d/%0d want=1/1",
                     iss_log.size(), done_log.size());
        end else begin
            total++;
            if (iss_log[0].c != t0 + 1 || iss_log[0].b != 10'd100 ||
                done_log[0].t != 32'h6000) begin
                bad++;
                $display("FAIL post_reset_issue got=%0d:%h want=1:6000",
                         iss_log[0].c - t0, done_log[0].t);
            end
        end
    endtask

    task automatic test_random();
        bit a, ok, v;
        int n, k, e;
        int seen[1000];
        iss_log.delete();
        done_log.delete();
        n = 0;
        k = 0;
        while (n < 1000 && k < 40000) begin
            v = $urandom_range(0, 9) < 7;
            tick(v, 10'($urandom_range(0, 15)),
                 {16'($urandom), 16'(n)}, a);
            if (a) n++;
            k++;
        end
        drain(5000, ok);
        total++;
        if (n != 1000 || !ok) begin
            bad++;
            $display("FAIL rand_accept got=%0d want=1000", n);
        end
        foreach (seen[i]) seen[i] = 0;
        foreach (done_log[i]) begin
            if (int'(done_log[i].t[15:0]) < 1000)
                seen[int'(done_log[i].t[15:0])]++;
        end
        e = 0;
        foreach (seen[i]) if (seen[i] != 1) e++;
        total++;
        if (e != 0 || done_log.size() != 1000 || iss_log.size() != 1000) begin
            bad++;
            $display("FAIL rand_once got=%0d/%0d bad_tags=%0d want=1000/1000/0",
                     iss_log.size(), done_log.size(), e);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_stream();
        test_back_to_back();
        test_fifo_full();
        test_head_priority();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
